// File: rtl/sample_packer_pkg.sv
// Shared encodings and per-component arithmetic helpers for the sample packer.
package sample_packer_pkg;

  typedef enum logic [1:0] {
    MODE_1B = 2'd0,
    MODE_2B = 2'd1,
    MODE_4B = 2'd2,
    MODE_8B = 2'd3
  } mode_e;

  // Pipeline depth from the pins to the packing stage.
  localparam int STAGES = 2;

  // Quantized bits kept per component for each mode.
  function automatic logic [3:0] width_of(input mode_e m);
    case (m)
      MODE_1B: width_of = 4'd1;
      MODE_2B: width_of = 4'd2;
      MODE_4B: width_of = 4'd4;
      default: width_of = 4'd8;
    endcase
  endfunction

  // Signed 8-bit add clamped to [-128, 127] instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) sat_add8 = sum[8] ? 8'h80 : 8'h7F;
    else                  sat_add8 = sum[7:0];
  endfunction

  // Pins arrive bit-reversed and Gray coded in offset binary:
  // reverse, Gray-decode, then flip the MSB to get two's complement.
  function automatic logic [7:0] gray_decode8(input logic [7:0] pins);
    logic [7:0] g;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) g[i] = pins[7-i];
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    gray_decode8 = {~b[7], b[6:0]};
  endfunction

endpackage

// File: rtl/sample_packer_quantize_iq.sv
// One I or Q component: Gray decode (stage 1), DC correct + quantize (stage 2).
// q is right-aligned; only the low width_of(mode) bits are meaningful.
module quantize_iq
  import sample_packer_pkg::*;
(
  input  logic       source_clk,
  input  logic       source_reset_n,
  input  logic [7:0] pins,
  input  logic [7:0] dc,
  input  logic [7:0] thresh,
  input  logic [1:0] mode,
  output logic [7:0] q
);

  logic [7:0]        x_r;
  logic [7:0]        dc_r;
  logic [7:0]        s;
  logic [7:0]        q_nxt;
  logic signed [8:0] s9;
  logic signed [8:0] t9;
  logic              mag;

  // Stage 1: decode pins; carry the correction alongside so it stays sample-aligned.
  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      x_r  <= '0;
      dc_r <= '0;
    end else begin
      x_r  <= gray_decode8(pins);
      dc_r <= dc;
    end
  end

  // Stage 2 logic: saturating correction, then quantize per mode.
  always_comb begin
    s   = sat_add8(x_r, dc_r);
    // 9-bit compare so thresh up to 255 and -thresh are both representable.
    s9  = {s[7], s};
    t9  = {1'b0, thresh};
    mag = (s9 >= t9) || (s9 < -t9);
    case (mode_e'(mode))
      MODE_1B: q_nxt = {7'd0, s[7]};
      MODE_2B: q_nxt = {6'd0, s[7], mag};
      MODE_4B: q_nxt = {4'd0, s[7:4]};
      default: q_nxt = s;
    endcase
  end

  // Stage 2 register.
  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) q <= '0;
    else                 q <= q_nxt;
  end

endmodule

// File: rtl/sample_packer.sv
// Gray-coded I/Q ADC front end: decode, DC correct, quantize, and pack
// enabled channels MSB-first into OUT_W-bit words for the packet streamer.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int ADC_W = 8,
  parameter int OUT_W = 16
) (
  input  logic                   source_clk,
  input  logic                   source_reset_n,
  input  logic                   in_valid,
  input  logic [NCH*2*ADC_W-1:0] ch_data,
  input  logic [NCH*2*ADC_W-1:0] dc_offset,
  input  logic [ADC_W-1:0]       thresh,
  input  logic [1:0]             mode,
  input  logic [NCH-1:0]         chan_mask,
  input  logic                   enable,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  output logic [15:0]            word_count,
  output logic                   config_err
);

  localparam int ACC_W  = 2*OUT_W;
  localparam int FILL_W = $clog2(OUT_W);
  localparam int TOT_W  = $clog2(ACC_W) + 1;
  localparam int PC_W   = $clog2(NCH+1);

  typedef struct packed {
    logic [1:0]       mode;
    logic [NCH-1:0]   mask;
    logic [ADC_W-1:0] thresh;
  } cfg_t;

  // [c][1] is I (upper byte of the channel), [c][0] is Q.
  logic [NCH-1:0][1:0][ADC_W-1:0] pins_a;
  logic [NCH-1:0][1:0][ADC_W-1:0] dc_a;
  logic [NCH-1:0][1:0][ADC_W-1:0] q_a;

  cfg_t               act;
  logic [STAGES:1]    vld_pipe;
  logic [PC_W-1:0]    pc;
  logic [3:0]         w;
  logic [7:0]         samp_b;
  logic               cfg_bad;
  logic [OUT_W-1:0]   samp_bits;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_app;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_nxt;
  logic [TOT_W-1:0]   tot;
  logic               emit;
  logic [OUT_W-1:0]   word;

  assign pins_a = ch_data;
  assign dc_a   = dc_offset;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar k = 0; k < 2; k++) begin : g_cmp
      quantize_iq u_q (
        .source_clk     (source_clk),
        .source_reset_n (source_reset_n),
        .pins           (pins_a[c][k]),
        .dc             (dc_a[c][k]),
        .thresh         (act.thresh),
        .mode           (act.mode),
        .q              (q_a[c][k])
      );
    end
  end

  // Valid travels with the data so packing sees in_valid delayed STAGES cycles.
  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) vld_pipe <= '0;
    else                 vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Active config only follows the inputs while packing is disabled.
  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      act        <= '0;
      config_err <= 1'b0;
    end else begin
      if (!enable) act <= '{mode: mode, mask: chan_mask, thresh: thresh};
      config_err <= cfg_bad;
    end
  end

  // Bits per sample from the active config; gating uses this directly so a
  // freshly latched config is honoured on the very first enabled cycle.
  always_comb begin
    pc = '0;
    for (int c = 0; c < NCH; c++) pc = pc + PC_W'(act.mask[c]);
    w       = width_of(mode_e'(act.mode));
    samp_b  = 8'(pc) * 8'(w) * 8'd2;
    cfg_bad = (samp_b == 8'd0) || (int'(samp_b) > OUT_W);
  end

  // Concatenate enabled channels: ch0 first, I before Q, each q MSB-first.
  always_comb begin
    samp_bits = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 1; k >= 0; k--) begin
        if (act.mask[c]) samp_bits = (samp_bits << w) | OUT_W'(q_a[c][k]);
      end
    end
  end

  // Append at the LSB end; the oldest OUT_W bits sit just below the fill+b mark.
  // Bits above that mark are stale and never selected.
  always_comb begin
    tot      = TOT_W'(fill) + TOT_W'(samp_b);
    acc_app  = (acc << samp_b) | ACC_W'(samp_bits);
    emit     = (tot >= TOT_W'(OUT_W));
    word     = OUT_W'(acc_app >> (tot - TOT_W'(OUT_W)));
    fill_nxt = emit ? FILL_W'(tot - TOT_W'(OUT_W)) : FILL_W'(tot);
  end

  // Pack stage: accumulate accepted samples, emit one word when full,
  // and drop any partial word as soon as enable goes low.
  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      acc        <= '0;
      fill       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!enable) begin
        fill <= '0;
      end else if (vld_pipe[STAGES] && !cfg_bad) begin
        acc  <= acc_app;
        fill <= fill_nxt;
        if (emit) begin
          out_data   <= word;
          out_valid  <= 1'b1;
          word_count <= word_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Parametrised successor to the fixed 2-channel 2-bit quantize/shift packer in the front end.
- Takes NCH Gray-coded I/Q ADC channels, converts Gray to two's complement, applies per-component DC correction, and quantizes to a runtime-selected width (1/2/4/8 bits).
- Packs enabled channels MSB-first into OUT_W-bit words with a one-cycle valid strobe, which feeds packet_streamer.
- Sits in the source_clk domain between ADC pins and the Ethernet streamer; configured from CPU out_ports.

Parameters:
- NCH, 4, number of I/Q channels (1..8).
- ADC_W, 8, bits per I or Q ADC component; must be 8.
- OUT_W, 16, packed output word width.

Ports:
- source_clk  in  1  sample clock (clk64).
- source_reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a sample is present on ch_data this cycle.
- ch_data  in  NCH*2*ADC_W  Gray-coded pins. Channel c uses bits [c*16+15 : c*16+8] for I and [c*16+7 : c*16] for Q.
- dc_offset  in  NCH*2*ADC_W  signed per-component correction, same layout as ch_data.
- thresh  in  ADC_W  unsigned magnitude threshold for 2-bit mode.
- mode  in  2  0=1b sign, 1=2b sign/mag, 2=4b, 3=8b.
- chan_mask  in  NCH  enabled channels.
- enable  in  1  packing enable.
- out_data  out  OUT_W  packed word.
- out_valid  out  1  one-cycle strobe qualifying out_data.
- word_count  out  16  words emitted; wraps.
- config_err  out  1  active configuration exceeds OUT_W bits per sample.

Behaviour:
- Reset is asynchronous and active-low. All registers clear, and every output resets to 0.
- Stage 1 (registered): per component, reverse the pin bit order, Gray-decode, then invert the MSB to give signed x.
- Stage 2 (registered): s = sat8(x + dc), where sat8 is a signed saturating add clamped to [-128, 127]. This replaces the wrapping add used previously. Quantize s to q:
  - mode 0: q = s[7].
  - mode 1: q = {s[7], (s >= thresh) || (s < -thresh)}. Compare at 9-bit signed width.
  - mode 2: q = s[7:4].
  - mode 3: q = s.
- Stage 3: pack. in_valid is pipelined alongside the data, so stage-3 acceptance is in_valid delayed 2 cycles.
- Config latch: mode, chan_mask and thresh are captured into active registers only while enable=0. Changes while enable=1 have no effect until enable toggles.
- Bits per sample: b = popcount(active_mask) * 2 * w, with w in {1, 2, 4, 8}.
  - If b > OUT_W or b == 0: config_err=1 and nothing is packed.
  - config_err updates one cycle after the latch.
- Accumulator: 2*OUT_W bits, fill counter 0..OUT_W-1.
  - Each accepted sample appends b bits at the LSB end (shift-left semantics).
  - Append order: channel 0 first, I before Q, each q MSB-first.
- Emission: when fill + b >= OUT_W, out_data gets the oldest OUT_W bits and out_valid=1 for one cycle.
  - fill becomes fill + b - OUT_W; the residue bits are kept.
  - Since b <= OUT_W and fill < OUT_W, at most one word is emitted per cycle.
- Latency: a sample completing a word on pins at cycle n gives out_valid at cycle n+3.
- word_count increments with each out_valid and wraps 0xFFFF to 0.
- enable falling: fill clears to 0 immediately and partial bits are discarded. A word being emitted that same cycle is still emitted. No further out_valid occurs.
- in_valid=0: the pipeline advances but the accumulator is untouched.
- Reset mid-word discards everything.
- Mask bits for channels >= NCH do not exist. Masks are width-NCH.

Decomposition:
- Package sample_packer_pkg holds:
  - mode encodings MODE_1B, MODE_2B, MODE_4B, MODE_8B;
  - function width_of(mode) returning w;
  - function sat_add8;
  - function gray_decode8 (bit reverse, decode, MSB invert).
- One sub-module is natural: quantize_iq, covering stages 1–2 for a single component. It is instantiated 2*NCH times with a generate loop.
- Packing and config logic stay in the top module.

Test Plan:
- Reset: hold source_reset_n=0 with in_valid toggling → out_valid, out_data, word_count and config_err all 0. Release mid-stream → first word appears only after a full OUT_W bits are accepted.
- Gray/DC/sat: ch0 I pins encoding x=+120, dc=+20 in mode 3 with mask=0001 (b=16) → I byte 0x7F (saturated). Q with x=-128 and dc=-5 → 0x80. Every in_valid cycle gives out_valid at cycle +3.
- 2-bit with 2 channels, mode 1, mask=0011, thresh=10 (b=8):
  - inputs s = +11, -11, +9, -10 on ch0I, ch0Q, ch1I, ch1Q → q = 01, 11, 00, 10 → byte 0x72.
  - Two samples → one word, e.g. 0x7272.
- Residue: mode 1 with mask=0111 (b=12) and 4 samples → 3 words on sample cycles 2, 3, 4. The bit stream must match a golden model exactly, including across word boundaries.
- Config: mode 3 with mask=0011 (b=32) → config_err=1 and no out_valid. Changing mode while enable=1 → ignored until enable cycles 0→1.
- Enable drop and wrap:
  - dropping enable with fill=8 → no partial word, and the next enable starts with fill=0;
  - preload 65535 words → word_count wraps to 0 on the next emission.
